timer_tick_gen: RTL and testbench
=================================

TIMER_TICK_GEN -- requirements
Module: timer_tick_gen

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning ref_clk_i synchronizer depth (legal 2..4).
REQ-002 SHALL have parameter PRESC_W, default 8, meaning prescaler compare width (cfg bits 15:8).
REQ-003 SHALL have port clk_i  input  1  system clock; one clock only.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ref_clk_i  input  1  reference clock, asynchronous to clk_i, slower than clk_i/2.
REQ-006 SHALL have port cfg_enable_i  input  1  timer enable (config ENABLE bit).
REQ-007 SHALL have port cfg_ref_clk_en_i  input  1  1 = count ref_clk_i rising edges, 0 = count clk_i cycles.
REQ-008 SHALL have port cfg_presc_en_i  input  1  prescaler enable.
REQ-009 SHALL have port cfg_presc_val_i  input  PRESC_W  prescaler compare value.
REQ-010 SHALL have port cnt_reset_i  input  1  single-cycle pulse from the RESET bit or a TIMER_RESET write.
REQ-011 SHALL have port tick_o  output  1  registered single-cycle increment strobe to the counter.
REQ-012 SHALL have port presc_cnt_o  output  PRESC_W  current prescaler count (status/debug).

Function
REQ-013 SHALL implement FSM states IDLE, ARM, RUN.
REQ-014 IDLE -> ARM when cfg_enable_i=1; ARM -> RUN unconditionally next cycle; any state -> IDLE when cfg_enable_i=0.
REQ-015 ARM SHALL load the edge-detector previous-sample flop with the current synchronized ref value and SHALL NOT generate a source event, so enabling never produces a spurious edge.
REQ-016 A toggle of cfg_ref_clk_en_i while in RUN SHALL force ARM for one cycle (re-prime), prescaler count held.
REQ-017 Source event (RUN only): ref mode = synchronized ref rising edge (sync_prev=0, sync_cur=1); internal mode = every clk_i cycle.
REQ-018 Prescaler disabled: tick_o SHALL be asserted the cycle after each source event.
REQ-019 Prescaler enabled: on a source event, if presc_cnt >= cfg_presc_val_i then tick and clear count to 0, else count+1; period = val+1 source events; val=0 gives a tick every event.
REQ-020 The >= compare SHALL make a mid-count decrease of cfg_presc_val_i tick on the next source event, never wrapping through 2^PRESC_W.
REQ-021 cnt_reset_i SHALL clear presc_cnt and suppress any tick from that cycle's source event; FSM state unchanged.
REQ-022 cnt_reset_i coincident with cfg_enable_i falling: IDLE entered, count cleared.
REQ-023 In IDLE, tick_o=0 and presc_cnt SHALL be cleared to 0.
REQ-024 Latency ref mode: ref_clk_i rising edge to tick_o = SYNC_STAGES+1 clk_i cycles (+/-1 for sampling uncertainty), prescaler disabled.
REQ-025 Internal mode: cfg_enable_i sampled high at edge N gives first tick_o high in cycle N+2 (ARM occupies N+1).
REQ-026 tick_o SHALL never be high on two consecutive cycles in ref mode.

Reset
REQ-027 On rst_ni low: FSM=IDLE, tick_o=0, presc_cnt_o=0, synchronizer and edge flops=0, asynchronously.
REQ-028 Reset deassertion mid-operation SHALL restart from IDLE; no tick before the ARM sequence completes.

Structure
REQ-029 FSM state typedef, PRESC_W default and the cfg bit-position constants SHALL live in the shared timer unit package.
REQ-030 The ref_clk_i synchronizer SHALL be a sub-module timer_ref_clk_sync (SYNC_STAGES flops, async reset to 0); all other logic SHALL stay in timer_tick_gen.

Verification
REQ-031 Internal mode, presc off, enable at edge 10 -> tick_o high every cycle from cycle 12; enable low -> tick_o 0 next cycle, presc_cnt_o=0.
REQ-032 Internal mode, presc on, val=3 -> tick_o every 4th cycle; change val to 1 when count=3 -> tick on next cycle, then every 2nd cycle.
REQ-033 Ref mode, ref_clk_i = clk_i/10, presc off -> exactly one tick per ref period, latency 3 cycles (SYNC_STAGES=2); ref_clk_i held high at enable -> no tick until next rising edge.
REQ-034 Presc on, val=255, 255 events then cnt_reset_i on the 256th event -> no tick, presc_cnt_o=0, next tick after 256 further events.
REQ-035 Toggle cfg_ref_clk_en_i mid-run and assert rst_ni low mid-count -> no spurious tick; all outputs 0 during reset; first tick only after ARM.

Source files
------------

// File: rtl/timer_tick_gen_pkg.sv
// Shared timer unit definitions: tick generator FSM states, prescaler width
// and the bit positions of the timer configuration register fields.
package timer_tick_gen_pkg;

   localparam int unsigned PRESC_W_DEFAULT     = 8;
   localparam int unsigned SYNC_STAGES_DEFAULT = 2;

   localparam int unsigned CFG_ENABLE_BIT      = 0;
   localparam int unsigned CFG_RESET_BIT       = 1;
   localparam int unsigned CFG_IRQ_EN_BIT      = 2;
   localparam int unsigned CFG_IEM_BIT         = 3;
   localparam int unsigned CFG_MODE_BIT        = 4;
   localparam int unsigned CFG_ONE_SHOT_BIT    = 5;
   localparam int unsigned CFG_PRESC_EN_BIT    = 6;
   localparam int unsigned CFG_REF_CLK_EN_BIT  = 7;
   localparam int unsigned CFG_PRESC_LSB       = 8;
   localparam int unsigned CFG_PRESC_MSB       = CFG_PRESC_LSB + PRESC_W_DEFAULT - 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2
   } tick_state_e;

endpackage

// File: rtl/timer_ref_clk_sync.sv
// Multi-flop synchronizer bringing the asynchronous reference clock into the
// system clock domain. Depth must be between 2 and 4.
module timer_ref_clk_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic async_i,
   output logic sync_o
);

   logic [SYNC_STAGES-1:0] sync_q;

   // Shift the raw reference level through the synchronizer chain.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      end
   end

   assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/timer_tick_gen.sv
// Timer tick generator: produces single-cycle increment strobes for the timer
// counter from either every system clock cycle or synchronized reference
// clock rising edges, optionally divided by a prescaler.
module timer_tick_gen
   import timer_tick_gen_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT,
   parameter int unsigned PRESC_W     = PRESC_W_DEFAULT
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               ref_clk_i,
   input  logic               cfg_enable_i,
   input  logic               cfg_ref_clk_en_i,
   input  logic               cfg_presc_en_i,
   input  logic [PRESC_W-1:0] cfg_presc_val_i,
   input  logic               cnt_reset_i,
   output logic               tick_o,
   output logic [PRESC_W-1:0] presc_cnt_o
);

   tick_state_e        state_q;
   tick_state_e        state_d;
   logic               ref_sync;
   logic               ref_prev_q;
   logic               ref_mode_q;
   logic               mode_toggle;
   logic               src_event;
   logic               presc_hit;
   logic               tick_d;
   logic               tick_q;
   logic [PRESC_W-1:0] presc_d;
   logic [PRESC_W-1:0] presc_q;

   timer_ref_clk_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_ref_sync (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .async_i (ref_clk_i),
      .sync_o  (ref_sync)
   );

   assign mode_toggle = cfg_ref_clk_en_i != ref_mode_q;

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: arm for one cycle on enable or source switch, drop to idle on disable.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (cfg_enable_i) state_d = ARM;
         ARM:     state_d = RUN;
         RUN:     if (mode_toggle) state_d = ARM;
         default: state_d = IDLE;
      endcase
      if (!cfg_enable_i) begin
         state_d = IDLE;
      end
   end

   // Source events only while running with a stable source, then prescaler and tick decision.
   always_comb begin
      src_event = 1'b0;
      presc_hit = presc_q >= cfg_presc_val_i;
      presc_d   = presc_q;
      if ((state_q == RUN) && cfg_enable_i && !mode_toggle) begin
         src_event = cfg_ref_clk_en_i ? (ref_sync & ~ref_prev_q) : 1'b1;
      end
      if (!cfg_enable_i || (state_q == IDLE) || cnt_reset_i) begin
         presc_d = '0;
      end else if (src_event && cfg_presc_en_i) begin
         presc_d = presc_hit ? '0 : presc_q + PRESC_W'(1);
      end
      tick_d = src_event && !cnt_reset_i && (!cfg_presc_en_i || presc_hit);
   end

   // Register the tick strobe, prescaler count, edge-detector history and source-select history.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tick_q     <= 1'b0;
         presc_q    <= '0;
         ref_prev_q <= 1'b0;
         ref_mode_q <= 1'b0;
      end else begin
         tick_q     <= tick_d;
         presc_q    <= presc_d;
         ref_prev_q <= ref_sync;
         ref_mode_q <= cfg_ref_clk_en_i;
      end
   end

   assign tick_o      = tick_q;
   assign presc_cnt_o = presc_q;

endmodule

// File: tb/tb_timer_tick_gen.sv
// Scoreboard bench for timer_tick_gen: stimulus pushes the reference model's
// expected outputs per cycle, a monitor pops and compares after each edge.
module tb_timer_tick_gen;

   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned PRESC_W     = 8;

   logic               clk_i;
   logic               rst_ni;
   logic               ref_clk_i;
   logic               cfg_enable_i;
   logic               cfg_ref_clk_en_i;
   logic               cfg_presc_en_i;
   logic [PRESC_W-1:0] cfg_presc_val_i;
   logic               cnt_reset_i;
   logic               tick_o;
   logic [PRESC_W-1:0] presc_cnt_o;

   typedef struct {
      logic               tick;
      logic [PRESC_W-1:0] cnt;
      logic               ref_mode;
   } expect_t;

   expect_t exp_q[$];
   int      checks = 0;
   int      errors = 0;

   logic               s_en       = 1'b0;
   logic               s_mode     = 1'b0;
   logic               s_pen      = 1'b0;
   logic [PRESC_W-1:0] s_val      = '0;
   int                 ref_period = 0;
   int                 ref_phase  = 0;
   logic               ref_level  = 1'b0;

   logic m_ref  [SYNC_STAGES+2];
   logic m_en   [3];
   logic m_mode [3];
   int   m_cnt;

   logic last_tick = 1'b0;
   logic last_mode = 1'b0;

   timer_tick_gen #(
      .SYNC_STAGES (SYNC_STAGES),
      .PRESC_W     (PRESC_W)
   ) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .ref_clk_i        (ref_clk_i),
      .cfg_enable_i     (cfg_enable_i),
      .cfg_ref_clk_en_i (cfg_ref_clk_en_i),
      .cfg_presc_en_i   (cfg_presc_en_i),
      .cfg_presc_val_i  (cfg_presc_val_i),
      .cnt_reset_i      (cnt_reset_i),
      .tick_o           (tick_o),
      .presc_cnt_o      (presc_cnt_o)
   );

   // Free-running system clock.
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
      end
   endtask

   // Drive one cycle of inputs at the falling edge and push the model's prediction for the next rising edge.
   task automatic applyStimulus(input logic rst, input logic crst);
      expect_t e;
      logic    allowed;
      logic    src;
      @(negedge clk_i);
      if (ref_period > 0) begin
         ref_level = (ref_phase % ref_period) < (ref_period / 2);
         ref_phase++;
      end
      rst_ni           = rst;
      cfg_enable_i     = s_en;
      cfg_ref_clk_en_i = s_mode;
      cfg_presc_en_i   = s_pen;
      cfg_presc_val_i  = s_val;
      cnt_reset_i      = crst;
      ref_clk_i        = ref_level;
      e.tick     = 1'b0;
      e.ref_mode = s_mode;
      if (!rst) begin
         for (int i = 0; i < SYNC_STAGES + 2; i++) m_ref[i] = 1'b0;
         for (int i = 0; i < 3; i++) begin
            m_en[i]   = 1'b0;
            m_mode[i] = s_mode;
         end
         m_cnt = 0;
      end else begin
         for (int i = SYNC_STAGES + 1; i > 0; i--) m_ref[i] = m_ref[i-1];
         m_ref[0] = ref_level;
         for (int i = 2; i > 0; i--) begin
            m_en[i]   = m_en[i-1];
            m_mode[i] = m_mode[i-1];
         end
         m_en[0]   = s_en;
         m_mode[0] = s_mode;
         allowed = m_en[0] && m_en[1] && m_en[2] && (m_mode[0] == m_mode[1]) && (m_mode[1] == m_mode[2]);
         src = allowed && (!m_mode[0] || (m_ref[SYNC_STAGES] && !m_ref[SYNC_STAGES+1]));
         if (!m_en[0] || !m_en[1] || crst) begin
            m_cnt = 0;
         end else if (src) begin
            if (!s_pen) begin
               e.tick = 1'b1;
            end else if (m_cnt >= int'(s_val)) begin
               e.tick = 1'b1;
               m_cnt  = 0;
            end else begin
               m_cnt++;
            end
         end
      end
      e.cnt = PRESC_W'(m_cnt);
      exp_q.push_back(e);
   endtask

   task automatic runCycles(input int n, input int crst_pct);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b1, ($urandom_range(99) < crst_pct));
      end
   endtask

   // Monitor: compare DUT outputs against the oldest prediction shortly after each rising edge.
   always @(posedge clk_i) begin
      expect_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checkOutput("tick_o", 32'(tick_o), 32'(e.tick));
         checkOutput("presc_cnt_o", 32'(presc_cnt_o), 32'(e.cnt));
         if (e.ref_mode && last_mode) begin
            checkOutput("ref_tick_back_to_back", 32'(tick_o & last_tick), 32'd0);
         end
         last_tick = tick_o;
         last_mode = e.ref_mode;
      end
   end

   // Directed scenarios followed by randomized configuration segments.
   initial begin
      rst_ni           = 1'b0;
      ref_clk_i        = 1'b0;
      cfg_enable_i     = 1'b0;
      cfg_ref_clk_en_i = 1'b0;
      cfg_presc_en_i   = 1'b0;
      cfg_presc_val_i  = '0;
      cnt_reset_i      = 1'b0;
      repeat (3) applyStimulus(1'b0, 1'b0);

      $display("[TB] internal mode, prescaler off");
      runCycles(8, 0);
      s_en = 1'b1;
      runCycles(20, 0);
      s_en = 1'b0;
      runCycles(5, 0);

      $display("[TB] internal mode, prescaler val 3 then 1");
      s_pen = 1'b1;
      s_val = 8'd3;
      s_en  = 1'b1;
      runCycles(14, 0);
      s_val = 8'd1;
      runCycles(12, 0);
      s_en = 1'b0;
      runCycles(3, 0);

      $display("[TB] ref mode, held high at enable then clk/10");
      s_pen      = 1'b0;
      s_mode     = 1'b1;
      ref_period = 0;
      ref_level  = 1'b1;
      runCycles(10, 0);
      s_en = 1'b1;
      runCycles(12, 0);
      ref_period = 10;
      ref_phase  = 5;
      runCycles(60, 0);
      s_en = 1'b0;
      runCycles(3, 0);

      $display("[TB] prescaler 255 with counter reset on the 256th event");
      s_mode = 1'b0;
      s_pen  = 1'b1;
      s_val  = 8'd255;
      s_en   = 1'b1;
      runCycles(257, 0);
      applyStimulus(1'b1, 1'b1);
      runCycles(300, 0);
      s_en = 1'b0;
      runCycles(3, 0);

      $display("[TB] source toggle mid-run and reset mid-count");
      s_val = 8'd5;
      s_en  = 1'b1;
      runCycles(20, 0);
      s_mode     = 1'b1;
      ref_period = 8;
      runCycles(40, 0);
      s_mode = 1'b0;
      runCycles(20, 0);
      s_val = 8'd20;
      runCycles(10, 0);
      repeat (3) applyStimulus(1'b0, 1'b0);
      runCycles(30, 0);
      s_en = 1'b0;
      runCycles(3, 0);

      $display("[TB] randomized segments");
      for (int seg = 0; seg < 40; seg++) begin
         if ($urandom_range(9) == 0) begin
            repeat (2) applyStimulus(1'b0, 1'b0);
         end
         s_en       = ($urandom_range(9) < 8);
         s_mode     = 1'($urandom_range(1));
         s_pen      = 1'($urandom_range(1));
         s_val      = ($urandom_range(3) == 0) ? PRESC_W'($urandom_range(255)) : PRESC_W'($urandom_range(7));
         ref_period = int'($urandom_range(24, 6));
         runCycles(int'($urandom_range(80, 20)), 3);
      end

      repeat (4) @(posedge clk_i);
      #2;
      checkOutput("scoreboard_drain", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
